ysyx_24070016_idu_stage: RTL

YSYX_24070016_IDU_STAGE -- requirements
Module: ysyx_24070016_idu_stage

---
 rtl/ysyx_24070016_idu_stage.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24070016_idu_stage.sv
// ysyx_24070016_idu_stage
//   RV32I decode stage: decodes the fetched instruction combinationally and
//   enqueues {regs, imm, ctrl, pc} into a DEPTH-entry FIFO. The execute side
//   pops entries through a valid/ready handshake. An entry pushed on cycle N
//   is visible on cycle N+1 at the earliest.
//
//   Optional feature: define YSYX_24070016_IDU_RV32M_EN to decode RV32M.
//   Without it, RV32M encodings are flagged illegal.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   flush                drop every queued entry
//   in_valid/in_ready    fetch handshake, with in_inst and in_pc
//   out_valid/out_ready  execute handshake
//   out_pc               PC of the head entry
//   out_regs             {rs1, rs2, rd}
//   out_imm              sign-extended immediate
//   out_ctrl             {rf_wen, alusrc1, alusrc2[1:0], aluop[4:0], branch[2:0],
//                         memop[2:0], memtoreg, mem_valid, mem_wren, ebreak, illegal}
//   dec_cnt              number of entries delivered (wraps)
module ysyx_24070016_idu_stage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [14:0]       out_regs,
    output logic [31:0]       out_imm,
    output logic [19:0]       out_ctrl,
    output logic [31:0]       dec_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = 15 + 32 + 20 + ADDR_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_LUI  = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b01010;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Shared OP / OP-IMM function decode; alt selects sub/sra.
    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [4:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // ---------------- decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'h000};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    logic        rf_wen, alusrc1, memtoreg, mem_valid, mem_wren, ebreak, illegal;
    logic [1:0]  alusrc2;
    logic [4:0]  aluop;
    logic [2:0]  branch, memop;
    logic [31:0] dec_imm;
    logic [19:0] dec_ctrl;

    always_comb begin
        rf_wen    = 1'b0;
        alusrc1   = 1'b0;
        alusrc2   = 2'b00;
        aluop     = ALU_ADD;
        branch    = 3'b000;
        memop     = 3'b000;
        memtoreg  = 1'b0;
        mem_valid = 1'b0;
        mem_wren  = 1'b0;
        ebreak    = 1'b0;
        illegal   = 1'b0;
        dec_imm   = '0;
        case (opcode)
            OPC_LUI: begin
                rf_wen  = 1'b1;
                alusrc2 = 2'b01;
                aluop   = ALU_LUI;
                dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                rf_wen  = 1'b1;
                alusrc1 = 1'b1;
                alusrc2 = 2'b01;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                rf_wen  = 1'b1;
                alusrc1 = 1'b1;
                alusrc2 = 2'b10;
                branch  = 3'b001;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                rf_wen  = 1'b1;
                alusrc1 = 1'b1;
                alusrc2 = 2'b10;
                branch  = 3'b010;
                dec_imm = imm_i;
                illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_imm = imm_b;
                case (f3)
                    3'b000:  begin aluop = ALU_SUB;  branch = 3'b100; end
                    3'b001:  begin aluop = ALU_SUB;  branch = 3'b101; end
                    3'b100:  begin aluop = ALU_SLT;  branch = 3'b110; end
                    3'b101:  begin aluop = ALU_SLT;  branch = 3'b111; end
                    3'b110:  begin aluop = ALU_SLTU; branch = 3'b110; end
                    3'b111:  begin aluop = ALU_SLTU; branch = 3'b111; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                rf_wen    = 1'b1;
                alusrc2   = 2'b01;
                memop     = f3;
                memtoreg  = 1'b1;
                mem_valid = 1'b1;
                dec_imm   = imm_i;
                illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                alusrc2   = 2'b01;
                memop     = f3;
                mem_valid = 1'b1;
                mem_wren  = 1'b1;
                dec_imm   = imm_s;
                illegal   = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                rf_wen  = 1'b1;
                alusrc2 = 2'b01;
                dec_imm = imm_i;
                aluop   = alu_of(f3, f3 == 3'b101 && f7 == 7'b0100000);
                if (f3 == 3'b001)
                    illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                rf_wen = 1'b1;
                if (f7 == 7'b0000000)
                    aluop = alu_of(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    aluop = alu_of(f3, 1'b1);
`ifdef YSYX_24070016_IDU_RV32M_EN
                else if (f7 == 7'b0000001)
                    aluop = {2'b10, f3};
`endif
                else
                    illegal = 1'b1;
            end
            OPC_FENCE: begin
                dec_imm = imm_i;
                illegal = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                dec_imm = imm_i;
                if (in_inst == INST_EBREAK) ebreak = 1'b1;
                else                        illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal entries still travel down the pipe, but carry no side effects.
        if (illegal) begin
            rf_wen    = 1'b0;
            alusrc1   = 1'b0;
            alusrc2   = 2'b00;
            aluop     = ALU_ADD;
            branch    = 3'b000;
            memop     = 3'b000;
            memtoreg  = 1'b0;
            mem_valid = 1'b0;
            mem_wren  = 1'b0;
            ebreak    = 1'b0;
        end
    end

    assign dec_ctrl = {rf_wen, alusrc1, alusrc2, aluop, branch, memop,
                       memtoreg, mem_valid, mem_wren, ebreak, illegal};

    // ---------------- queue ----------------
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] ent_in, ent_out;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ent_in    = {in_inst[19:15], in_inst[24:20], in_inst[11:7], dec_imm, dec_ctrl, in_pc};
    assign in_ready  = ~rst & ~flush & (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ent_out   = mem[rd_ptr];
    assign {out_regs, out_imm, out_ctrl, out_pc} = ent_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            dec_cnt <= '0;
        end else begin
            if (pop)
                dec_cnt <= dec_cnt + 32'd1;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is cleared on reset so out_* read as zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= ent_in;
        end
    end

endmodule
